// File: rtl/kingdom_constant_arbiter.sv
// rtl/kingdom_constant_arbiter.sv - round-robin arbiter in front of the sacred-constant table
//
// Purpose:
//   Several requesters share one 8-entry, 64-bit constant table. The arbiter
//   grants at most one lookup per cycle, choosing round-robin from a rotating
//   priority pointer. Accepted lookups pass through two register stages:
//   stage 1 captures {id, idx} and stage 2 drives {id, table[idx]} onto the
//   shared response bus. Responses therefore appear two cycles after
//   acceptance. A saturating counter records accepted lookups.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   en            in   arbitration enable; in-flight lookups finish regardless
//   req_valid     in   [NUM_REQ]    per-requester lookup request
//   req_idx       in   [3*NUM_REQ]  per-requester index, requester i at [3i+2:3i]
//   req_ready     out  [NUM_REQ]    one-hot combinational grant
//   rsp_valid     out  response strobe, one cycle per accepted lookup
//   rsp_id        out  [ID_W]       requester owning the response (held when idle)
//   rsp_data      out  [64]         constant value (held when idle)
//   busy          out  any lookup in flight
//   lookup_count  out  [CNT_W]      accepted lookups, saturating

module kingdom_constant_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [3*NUM_REQ-1:0] req_idx,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [63:0]          rsp_data,
    output logic                 busy,
    output logic [CNT_W-1:0]     lookup_count
);

    // ------------------------------------------------------------------
    // Constant table. Entries 0..5 are IEEE-754 double bit patterns;
    // entries 6 and 7 are plain integers zero-extended to 64 bits.
    // ------------------------------------------------------------------
    function automatic logic [63:0] f_const(input logic [2:0] idx);
        logic [63:0] v;
        case (idx)
            3'd0:    v = 64'h3FF9_E377_9B97_F4A8; // phi
            3'd1:    v = 64'h4004_F1BB_CDCB_F254; // phi squared
            3'd2:    v = 64'h3FD8_722D_0E56_0419; // 1 / phi squared
            3'd3:    v = 64'h4009_21FB_5444_2D18; // pi
            3'd4:    v = 64'h4005_BF0A_8B14_5769; // e
            3'd5:    v = 64'h4008_0000_0000_0000; // trinity, 3.0
            3'd6:    v = 64'd30;                  // perfection
            3'd7:    v = 64'd123;                 // lucas_10
            default: v = 64'd0;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ID_W-1:0]  r_ptr;        // requester with highest priority this cycle
    logic             r_s1_valid;
    logic [ID_W-1:0]  r_s1_id;
    logic [2:0]       r_s1_idx;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [63:0]      r_rsp_data;
    logic [CNT_W-1:0] r_count;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_accept;
    logic [2:0]         w_acc_idx;
    logic [ID_W-1:0]    w_ptr_next;
    int                 w_pos;

    // Scan requesters starting at r_ptr and wrapping; the first valid one
    // wins. The grant only ever lands on a valid requester, so a grant
    // and an acceptance are the same event.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_accept   = 1'b0;
        w_pos      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (en && !w_accept && req_valid[w_pos[ID_W-1:0]]) begin
                w_accept   = 1'b1;
                w_grant_id = w_pos[ID_W-1:0];
            end
        end
        w_grant[w_grant_id] = w_accept;
    end

    assign w_acc_idx  = req_idx[3*w_grant_id +: 3];

    // The winner drops to lowest priority on the next cycle.
    assign w_ptr_next = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0
                                                            : w_grant_id + 1'b1;

    // ------------------------------------------------------------------
    // Pointer and accepted-lookup counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_next;
            if (r_count != {CNT_W{1'b1}}) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture requester tag and index at acceptance
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_id  <= w_grant_id;
                r_s1_idx <= w_acc_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: table read onto the response bus. Tag and data only move
    // when a lookup arrives so the bus holds its last response when idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rsp_id   <= r_s1_id;
                r_rsp_data <= f_const(r_s1_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready    = w_grant;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_data     = r_rsp_data;
    assign busy         = r_s1_valid | r_rsp_valid;
    assign lookup_count = r_count;

endmodule

// File: tb/tb_kingdom_constant_arbiter.sv
// tb/tb_kingdom_constant_arbiter.sv - self-checking bench for kingdom_constant_arbiter

module tb_kingdom_constant_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [11:0] req_idx;

    logic [3:0]  req_ready,    s_req_ready;
    logic        rsp_valid,    s_rsp_valid;
    logic [1:0]  rsp_id,       s_rsp_id;
    logic [63:0] rsp_data,     s_rsp_data;
    logic        busy,         s_busy;
    logic [15:0] lookup_count;
    logic [3:0]  s_lookup_count;

    always #5 clk = ~clk;

    kingdom_constant_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .lookup_count(lookup_count)
    );

    kingdom_constant_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_idx(req_idx), .req_ready(s_req_ready),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data),
        .busy(s_busy), .lookup_count(s_lookup_count)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: table values, a rotating priority number, and a
    // queue of responses each stamped with the cycle it must appear in.
    // ------------------------------------------------------------------
    logic [63:0] table_m [8] = '{64'h3FF9E3779B97F4A8, 64'h4004F1BBCDCBF254,
                                 64'h3FD8722D0E560419, 64'h400921FB54442D18,
                                 64'h4005BF0A8B145769, 64'h4008000000000000,
                                 64'd30, 64'd123};

    typedef struct {
        int          due;
        logic [1:0]  id;
        logic [63:0] data;
    } rsp_t;

    rsp_t        mq[$];
    int          mptr  = 0;
    int          mcount = 0;
    logic [1:0]  last_id = '0;
    logic [63:0] last_data = '0;

    function automatic int model_winner(input int p, input logic e, input logic [3:0] v);
        if (!e) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mptr      = 0;
            mcount    = 0;
            last_id   = '0;
            last_data = '0;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_count", lookup_count, 0);
            chk("rst_sat_count", s_lookup_count, 0);
        end else begin
            int          w;
            logic [3:0]  exp_ready;
            logic        exp_rv;
            logic        exp_busy;
            w         = model_winner(mptr, en, req_valid);
            exp_ready = (w < 0) ? 4'b0000 : 4'(1 << w);
            chk("req_ready", req_ready, exp_ready);
            chk("sat_req_ready", s_req_ready, exp_ready);

            exp_busy = (mq.size() > 0);
            exp_rv   = (mq.size() > 0) && (mq[0].due == cyc);
            if (exp_rv) begin
                last_id   = mq[0].id;
                last_data = mq[0].data;
                void'(mq.pop_front());
            end
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("rsp_id", rsp_id, last_id);
            chk("rsp_data", rsp_data, last_data);
            chk("busy", busy, exp_busy);
            chk("sat_rsp_valid", s_rsp_valid, exp_rv);
            chk("sat_rsp_data", s_rsp_data, last_data);
            chk("sat_rsp_id", s_rsp_id, last_id);
            chk("sat_busy", s_busy, exp_busy);
            chk("lookup_count", lookup_count, (mcount > 65535) ? 65535 : mcount);
            chk("sat_lookup_count", s_lookup_count, (mcount > 15) ? 15 : mcount);

            if (w >= 0) begin
                logic [2:0] ix;
                ix = req_idx[3*w +: 3];
                mq.push_back('{due: cyc + 2, id: 2'(w), data: table_m[ix]});
                mptr   = (w + 1) % NREQ;
                mcount = mcount + 1;
            end
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed literal expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_id(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v == 4'(1 << k)) return k;
        return -1;
    endfunction

    int exp_rr [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        rst_n = 1'b0; en = 1'b0; req_valid = '0; req_idx = '0;
        repeat (3) tick();
        rst_n = 1'b1; en = 1'b1;

        // Round-robin from reset: all four requesters held valid.
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) req_idx[3*i +: 3] = 3'(i);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("rr_grant_%0d", c), 64'(onehot_id(req_ready)), 64'(exp_rr[c]));
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Single lookup: requester 2, idx 5.
        req_valid = 4'b0100; req_idx = '0; req_idx[8:6] = 3'd5;
        @(negedge clk);
        chk("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_id", rsp_id, 2);
        chk("single_rsp_data", rsp_data, 64'h4008000000000000);
        chk("single_count", lookup_count, 9);
        repeat (3) tick();

        // Sweep: requester 0 reads every entry back-to-back.
        for (int j = 0; j < 10; j++) begin
            if (j < 8) begin
                req_valid = 4'b0001; req_idx = '0; req_idx[2:0] = 3'(j);
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
            if (j == 8) chk("sweep_idx6", rsp_data, 64'h000000000000001E);
            if (j == 9) chk("sweep_idx7", rsp_data, 64'h000000000000007B);
            tick();
        end
        repeat (2) tick();

        // Enable gating: requesters 1 and 3 wait while en is low.
        en = 1'b0; req_valid = 4'b1010; req_idx = '0;
        req_idx[5:3] = 3'd4; req_idx[11:9] = 3'd7;
        repeat (3) begin
            @(negedge clk);
            chk("gated_ready", req_ready, 4'b0000);
            chk("gated_rsp_valid", rsp_valid, 0);
            tick();
        end
        en = 1'b1;
        @(negedge clk);
        chk("en_grant_1", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("en_grant_3", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("busy_after_1", busy, 1);
        tick();
        @(negedge clk);
        chk("busy_after_2", busy, 1);
        chk("en_rsp_id", rsp_id, 3);
        chk("en_rsp_data", rsp_data, 64'd123);
        tick();
        @(negedge clk);
        chk("busy_after_3", busy, 0);
        chk("count_19", lookup_count, 19);
        chk("sat_count_15", s_lookup_count, 15);
        tick();

        // Reset mid-flight: accept, then reset one cycle later.
        req_valid = 4'b0001; req_idx = '0; req_idx[2:0] = 3'd3;
        @(negedge clk);
        chk("pre_rst_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0; rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", rsp_valid, 0);
            chk("post_rst_count", lookup_count, 0);
            tick();
        end
        req_valid = 4'b1010; req_idx = '0; req_idx[5:3] = 3'd1; req_idx[11:9] = 3'd2;
        @(negedge clk);
        chk("post_rst_grant", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("post_rst_grant_next", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
